dmem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_ctrl.sv | 134 +++++++++++++
 tb/tb_dmem_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_LATENCY     = 3;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read.
// rd_zero_i forces the read register to zero instead of the array word.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IW          = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic          rd_zero_i,
  input  logic [IW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_o <= '0;
    else if (re_i) rdata_o <= rd_zero_i ? '0 : mem[idx_i];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: fixed-latency load/store with pipeline stall.
// Optional stall counter port stall_cnt_o is enabled by defining DMEM_PERF_CNT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        misalign_o
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int IW = idx_width(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_e           op_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          mis_q;
  logic          stall, commit;

  logic          req;
  op_e           live_op, cur_op;
  logic [IW-1:0] live_idx, cur_idx;
  logic          live_mis, cur_mis;
  logic [31:0]   cur_wdata;
  logic          unused_addr;

  assign req         = MemRead_i | MemWrite_i;
  assign live_op     = MemWrite_i ? OP_STORE : OP_LOAD;
  assign live_idx    = addr_i[IW+1:2];
  assign live_mis    = |addr_i[1:0];
  assign unused_addr = ^addr_i[31:IW+2];

  // With LATENCY=1 the commit happens on the edge that leaves IDLE, before
  // the latches hold anything, so IDLE commits use the live inputs.
  assign cur_op    = (state_q == IDLE) ? live_op  : op_q;
  assign cur_idx   = (state_q == IDLE) ? live_idx : idx_q;
  assign cur_mis   = (state_q == IDLE) ? live_mis : mis_q;
  assign cur_wdata = (state_q == IDLE) ? data_i   : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (LATENCY == 1) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The pipeline must not see a stall while reset is held.
  assign stall_o = stall & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_LOAD;
      idx_q      <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_o <= commit & cur_mis;
      if (state_q == IDLE && req) begin
        op_q    <= live_op;
        idx_q   <= live_idx;
        wdata_q <= data_i;
        mis_q   <= live_mis;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IW         (IW)
  ) u_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (commit & (cur_op == OP_STORE) & ~cur_mis),
    .re_i     (commit & (cur_op == OP_LOAD)),
    .rd_zero_i(cur_mis),
    .idx_i    (cur_idx),
    .wdata_i  (cur_wdata),
    .rdata_o  (data_o)
  );

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != '1)    stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table plus scoreboard, with
// hand sequences for reset-during-access and a LATENCY=1 instance.
module tb_dmem_ctrl;

  localparam int LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, data_i;
  logic [31:0] data_o;
  logic        stall_o, misalign_o;

  logic        rd1, wr1;
  logic [31:0] addr1, wd1;
  logic [31:0] data1;
  logic        stall1, mis1;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] stall_cnt, stall_cnt1;
`endif

  always #5 clk_i = ~clk_i;

  dmem_ctrl #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o)
`ifdef DMEM_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  dmem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (rd1),
    .MemWrite_i (wr1),
    .addr_i     (addr1),
    .data_i     (wd1),
    .data_o     (data1),
    .stall_o    (stall1),
    .misalign_o (mis1)
`ifdef DMEM_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt1)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        mis;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic prev_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: the DONE cycle is the first non-stall cycle after a stall.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !stall_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: DONE seen with no expected entry at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_data", data_o, e.data);
          chk("done_mis", {31'd0, misalign_o}, {31'd0, e.mis});
        end
      end else if (misalign_o) begin
        checks++;
        errors++;
        $display("FAIL mis_spurious: misalign_o=1 outside DONE at %0t", $time);
      end
      prev_stall <= stall_o;
    end
  end

  // Entered and left at posedge+1; checks the full stall pattern 1..1,0.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] ed, input logic em);
    exp_t e;
    e.data = ed;
    e.mis  = em;
    sb.push_back(e);
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    data_i     = d;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk_i);
      chk("stall_hi", {31'd0, stall_o}, 32'd1);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("stall_done", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  task automatic access1(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] ed);
    rd1 = rd; wr1 = wr; addr1 = a; wd1 = d;
    @(negedge clk_i);
    chk("l1_stall_hi", {31'd0, stall1}, 32'd1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("l1_stall_done", {31'd0, stall1}, 32'd0);
    chk("l1_data", data1, ed);
    @(posedge clk_i); #1;
    rd1 = 1'b0; wr1 = 1'b0;
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{0, 1, 32'h010, 32'h12345678, 32'h00000000, 0};
    vecs[1]  = '{1, 0, 32'h010, 32'h0,        32'h12345678, 0};
    vecs[2]  = '{0, 1, 32'h000, 32'h0000000A, 32'h12345678, 0};
    vecs[3]  = '{0, 1, 32'h004, 32'h0000000B, 32'h12345678, 0};
    vecs[4]  = '{1, 0, 32'h000, 32'h0,        32'h0000000A, 0};
    vecs[5]  = '{1, 0, 32'h004, 32'h0,        32'h0000000B, 0};
    vecs[6]  = '{0, 1, 32'h400, 32'h00000077, 32'h0000000B, 0};
    vecs[7]  = '{1, 0, 32'h402, 32'h0,        32'h00000000, 1};
    vecs[8]  = '{1, 0, 32'h400, 32'h0,        32'h00000077, 0};
    vecs[9]  = '{0, 1, 32'h404, 32'h00000055, 32'h00000077, 0};
    vecs[10] = '{1, 0, 32'h004, 32'h0,        32'h00000055, 0};
    vecs[11] = '{0, 1, 32'h0C0, 32'h00000099, 32'h00000055, 0};
    vecs[12] = '{0, 1, 32'h0C1, 32'h0000FFFF, 32'h00000055, 1};
    vecs[13] = '{1, 0, 32'h0C0, 32'h0,        32'h00000099, 0};
    vecs[14] = '{1, 1, 32'h008, 32'h00000033, 32'h00000099, 0};
    vecs[15] = '{1, 0, 32'h008, 32'h0,        32'h00000033, 0};
    vecs[16] = '{0, 1, 32'h020, 32'h11111111, 32'h00000033, 0};
    vecs[17] = '{1, 0, 32'h020, 32'h0,        32'h11111111, 0};

    rst_i = 1'b1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = '0; data_i = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_data", data_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("idle_stall", {31'd0, stall_o}, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    chk("cnt_rst", stall_cnt, 32'd0);
`endif

    foreach (vecs[i])
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_data, vecs[i].exp_mis);

    // Reset during the second stall cycle of a store: it must never commit.
    MemWrite_i = 1'b1; addr_i = 32'h020; data_i = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("rb_stall1", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    chk("rb_stall2", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rb_stall_drop", {31'd0, stall_o}, 32'd0);
    chk("rb_data_rst", data_o, 32'd0);
    MemWrite_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
`ifdef DMEM_PERF_CNT_EN
    chk("cnt_rst2", stall_cnt, 32'd0);
`endif

    access(1, 0, 32'h020, 32'h0,        32'h11111111, 0);
    access(1, 0, 32'h010, 32'h0,        32'h12345678, 0);
    access(0, 1, 32'h010, 32'hCAFE0001, 32'h12345678, 0);
    access(1, 0, 32'h000, 32'h0,        32'h00000077, 0);
`ifdef DMEM_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd12);
`endif
    chk("sb_drained", sb.size(), 32'd0);

    // LATENCY=1 instance: one stall cycle per access, wrap at 1 KiB.
    access1(0, 1, 32'h008, 32'h0000005A, 32'h00000000);
    access1(1, 0, 32'h008, 32'h0,        32'h0000005A);
    access1(1, 0, 32'h408, 32'h0,        32'h0000005A);
    access1(1, 0, 32'h00A, 32'h0,        32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
